prng_step_recover: RTL and testbench
====================================

Name: prng_step_recover

Overview:
Receive-side companion to the counter-based PRNG. The PRNG emits byte pairs x = hi+lo and y = hi+2*lo (mod 256) from a 16-bit step count {hi,lo}. This block accepts the (x,y) stream and inverts each pair back to the 16-bit step. It tracks sequence continuity with an acquire/lock state machine and counts continuity errors. It sits at the checker end of the PRNG link.

Parameters:
LOCK_THRESH, 4, consecutive in-sequence beats needed to declare lock (range 2..15)
UNLOCK_THRESH, 3, consecutive out-of-sequence beats while locked that drop lock (range 1..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
clear  input  1  synchronous: force SEARCH, zero err_count and internal counters
in_valid  input  1  in_x/in_y valid
in_ready  output  1  block can accept a beat
in_x  input  8  PRNG x byte
in_y  input  8  PRNG y byte
out_valid  output  1  out_step/out_match valid
out_ready  input  1  downstream accepts output
out_step  output  16  recovered step {hi,lo}
out_match  output  1  recovered step equalled expected step
locked  output  1  FSM in LOCKED
err_count  output  16  saturating count of mismatches seen while LOCKED

Behaviour:
- Decode, combinational on the input: lo = (in_y - in_x) mod 256; hi = (in_x - lo) mod 256; dec = {hi,lo}. All arithmetic is 8-bit wrap.
- Handshake: a beat is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready, so there is a single output register.
- The output holds stable while out_valid && !out_ready. out_valid clears after a handshake with no new accepted beat.
- Latency: the beat is accepted at edge N; out_valid, out_step = dec and out_match appear after edge N. locked and err_count update on the same edge.
- Internal state: exp_step[15:0], run_cnt[3:0], miss_cnt[3:0]. The 16-bit increment wraps, so 0xFFFF is followed by 0x0000 and that counts as a match.
- FSM, evaluated only on accepted beats:
  - SEARCH: exp_step <= dec+1; run_cnt <= 1; go to ACQUIRE; out_match = 0.
  - ACQUIRE, match (dec == exp_step): run_cnt++, exp_step <= dec+1. If run_cnt+1 == LOCK_THRESH, go to LOCKED and set miss_cnt <= 0.
  - ACQUIRE, mismatch: run_cnt <= 1, exp_step <= dec+1 (resync to this beat); stay in ACQUIRE.
  - LOCKED, match: miss_cnt <= 0, exp_step <= exp_step+1.
  - LOCKED, mismatch: err_count++ (saturates at 0xFFFF); exp_step <= exp_step+1 (flywheel, no resync). If miss_cnt+1 == UNLOCK_THRESH, go to SEARCH and zero run_cnt/miss_cnt; otherwise miss_cnt++.
- locked = (state == LOCKED), registered.
- clear:
  - Takes priority over a simultaneous beat; that beat is still accepted and its output is produced as if the FSM were in SEARCH (out_match = 0).
  - err_count <= 0; FSM enters ACQUIRE via the SEARCH action on that beat, or SEARCH if no beat.
- Reset values: out_valid 0, out_step 0, out_match 0, locked 0, err_count 0. Internal: state SEARCH, exp_step 0, run_cnt 0, miss_cnt 0.
- in_ready = 1 while in reset, since out_valid = 0; beats offered while rst is high are ignored.
- Reset asserted mid-lock returns all state to the reset values asynchronously; no partial output is emitted.

Test Plan:
1. Decode: reset, then one beat x=3, y=5 -> next cycle out_valid=1, out_step=0x0102, out_match=0, locked=0. Also x=254, y=253 -> out_step=0xFFFF.
2. Lock, LOCK_THRESH=4: beats (0,0),(1,2),(2,4),(3,6),(4,8),(5,10) back-to-back with out_ready=1 -> out_match 0,1,1,1,1,1; locked rises with the 4th output; out_step = 0..5.
3. Wrap: locked, feed steps 0xFFFE (253,251), 0xFFFF (254,253), 0x0000 (0,0) -> all out_match=1, err_count=0, locked stays 1.
4. Errors/flywheel: locked at expected step 10. Feed one corrupt beat (0,0), then step 11 (11,22) -> out_match 0 then 1, err_count=1, locked stays 1. Then three corrupt beats -> err_count=4, locked falls with the 3rd corrupt output.
5. Backpressure: out_ready=0 while out_valid=1 -> in_ready=0, out_step held, no beat consumed for 5 cycles. Release -> next beat accepted; no beat lost or duplicated.
6. Reset/clear: assert rst asynchronously mid-lock -> all outputs 0 immediately. Separately, a clear pulse with a concurrent beat -> err_count=0, locked=0, that beat's out_match=0, and re-lock after LOCK_THRESH beats.

Source files
------------

// File: rtl/prng_step_recover.sv
// Inverts PRNG (x,y) byte pairs to 16-bit steps and tracks continuity with a SEARCH/ACQUIRE/LOCKED FSM.
// One-cycle latency through a single output register; in_ready drops only while that register is held.
module prng_step_recover #(
  parameter int LOCK_THRESH   = 4,
  parameter int UNLOCK_THRESH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_step,
  output logic        out_match,
  output logic        locked,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  localparam logic [3:0] LOCK_T   = 4'(LOCK_THRESH);
  localparam logic [3:0] UNLOCK_T = 4'(UNLOCK_THRESH);

  state_t      state_q, state_d;
  logic [15:0] exp_q, exp_d;
  logic [3:0]  run_q, run_d;
  logic [3:0]  miss_q, miss_d;
  logic        ov_q, ov_d;
  logic [15:0] step_q, step_d;
  logic        match_q, match_d;
  logic [15:0] err_q, err_d;

  logic [7:0]  lo, hi;
  logic [15:0] dec;
  logic        accept, hit;

  assign lo       = in_y - in_x;
  assign hi       = in_x - lo;
  assign dec      = {hi, lo};
  assign in_ready = !ov_q || out_ready;
  assign accept   = in_valid && in_ready;
  // A beat arriving with clear is judged as if in SEARCH, so it can never match.
  assign hit      = (state_q != SEARCH) && !clear && (dec == exp_q);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    miss_d  = miss_q;
    ov_d    = ov_q;
    step_d  = step_q;
    match_d = match_q;
    err_d   = err_q;

    if (accept) begin
      ov_d    = 1'b1;
      step_d  = dec;
      match_d = hit;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end

    if (clear) begin
      err_d  = 16'd0;
      miss_d = 4'd0;
      if (accept) begin
        state_d = ACQUIRE;
        exp_d   = dec + 16'd1;
        run_d   = 4'd1;
      end else begin
        state_d = SEARCH;
        run_d   = 4'd0;
      end
    end else if (accept) begin
      case (state_q)
        SEARCH: begin
          exp_d   = dec + 16'd1;
          run_d   = 4'd1;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          exp_d = dec + 16'd1;
          if (hit) begin
            run_d = run_q + 4'd1;
            if (run_q + 4'd1 == LOCK_T) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end else begin
            run_d = 4'd1;
          end
        end
        LOCKED: begin
          // Flywheel: the expected step advances regardless of what arrived.
          exp_d = exp_q + 16'd1;
          if (hit) begin
            miss_d = 4'd0;
          end else begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (miss_q + 4'd1 == UNLOCK_T) begin
              state_d = SEARCH;
              run_d   = 4'd0;
              miss_d  = 4'd0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEARCH;
      exp_q   <= 16'd0;
      run_q   <= 4'd0;
      miss_q  <= 4'd0;
      ov_q    <= 1'b0;
      step_q  <= 16'd0;
      match_q <= 1'b0;
      err_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
      ov_q    <= ov_d;
      step_q  <= step_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = ov_q;
  assign out_step  = step_q;
  assign out_match = match_q;
  assign locked    = (state_q == LOCKED);
  assign err_count = err_q;

endmodule

// File: tb/tb_prng_step_recover.sv
// Directed bench for prng_step_recover with a cycle-level reference model and literal spot checks.
module tb_prng_step_recover;

  localparam int LOCK_THRESH   = 4;
  localparam int UNLOCK_THRESH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = 8'd0;
  logic [7:0]  in_y = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_step;
  logic        out_match;
  logic        locked;
  logic [15:0] err_count;

  int errors = 0;
  int checks = 0;

  prng_step_recover #(.LOCK_THRESH(LOCK_THRESH), .UNLOCK_THRESH(UNLOCK_THRESH)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_step(out_step),
    .out_match(out_match), .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: recovered step solved algebraically, continuity tracked as counts of beats.
  int  m_ov, m_step, m_match, m_lock, m_err, m_ref, m_run, m_miss, m_exp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ov = 0; m_step = 0; m_match = 0; m_lock = 0; m_err = 0;
      m_ref = 0; m_run = 0; m_miss = 0; m_exp = 0;
    end else begin
      int x, y, s, acc, h;
      x = int'(in_x); y = int'(in_y);
      s = ((2 * x - y) & 255) * 256 + ((y - x) & 255);
      acc = (in_valid && (m_ov == 0 || out_ready)) ? 1 : 0;
      h = (acc != 0 && m_ref != 0 && !clear && s == m_exp) ? 1 : 0;
      if (acc != 0) begin
        m_ov = 1; m_step = s; m_match = h;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (clear) begin
        m_err = 0; m_lock = 0; m_miss = 0;
        if (acc != 0) begin m_ref = 1; m_run = 1; m_exp = (s + 1) % 65536; end
        else begin m_ref = 0; m_run = 0; end
      end else if (acc != 0) begin
        if (m_ref == 0) begin
          m_ref = 1; m_run = 1; m_exp = (s + 1) % 65536;
        end else if (m_lock == 0) begin
          m_exp = (s + 1) % 65536;
          if (h != 0) begin
            m_run = m_run + 1;
            if (m_run >= LOCK_THRESH) begin m_lock = 1; m_miss = 0; end
          end else begin
            m_run = 1;
          end
        end else begin
          m_exp = (m_exp + 1) % 65536;
          if (h != 0) m_miss = 0;
          else begin
            m_err = (m_err < 65535) ? m_err + 1 : 65535;
            m_miss = m_miss + 1;
            if (m_miss >= UNLOCK_THRESH) begin
              m_lock = 0; m_ref = 0; m_run = 0; m_miss = 0;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model.out_valid", 32'(out_valid), 32'(m_ov));
      chk("model.in_ready", 32'(in_ready), 32'((m_ov == 0 || out_ready) ? 1 : 0));
      chk("model.locked", 32'(locked), 32'(m_lock));
      chk("model.err_count", 32'(err_count), 32'(m_err));
      if (m_ov != 0) begin
        chk("model.out_step", 32'(out_step), 32'(m_step));
        chk("model.out_match", 32'(out_match), 32'(m_match));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    int n;
    in_valid = 1'b1; in_x = x; in_y = y;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      errors++; checks++;
      $display("FAIL send_timeout: in_ready stuck at 0, required 1");
    end
    tick();
  endtask

  task automatic send_step(input logic [15:0] s);
    logic [7:0] h, l;
    h = s[15:8]; l = s[7:0];
    send(h + l, h + l + l);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    // Beat offered during reset must be ignored.
    in_valid = 1'b1; in_x = 8'd3; in_y = 8'd5;
    #1 chk("rst.in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #2 chk("rst.out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_step", 32'(out_step), 32'd0);
    chk("reset.locked", 32'(locked), 32'd0);
    chk("reset.err", 32'(err_count), 32'd0);

    // Decode
    send(8'd3, 8'd5);
    chk("dec1.valid", 32'(out_valid), 32'd1);
    chk("dec1.step", 32'(out_step), 32'h0102);
    chk("dec1.match", 32'(out_match), 32'd0);
    chk("dec1.locked", 32'(locked), 32'd0);
    send(8'd254, 8'd253);
    chk("dec2.step", 32'(out_step), 32'hFFFF);
    in_valid = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;

    // Lock acquisition
    for (int k = 0; k < 6; k++) begin
      send(8'(k), 8'(2 * k));
      chk($sformatf("lock.step%0d", k), 32'(out_step), 32'(k));
      chk($sformatf("lock.match%0d", k), 32'(out_match), (k == 0) ? 32'd0 : 32'd1);
      chk($sformatf("lock.locked%0d", k), 32'(locked), (k >= 3) ? 32'd1 : 32'd0);
    end

    // Wrap across 0xFFFF while locked
    clear = 1'b1;
    send_step(16'hFFFA);
    clear = 1'b0;
    for (int s = 16'hFFFB; s <= 16'hFFFD; s++) send_step(16'(s));
    chk("wrap.locked_pre", 32'(locked), 32'd1);
    send(8'd253, 8'd251);
    chk("wrap.fffe", {15'd0, out_match, out_step}, 32'h1FFFE);
    send(8'd254, 8'd253);
    chk("wrap.ffff", {15'd0, out_match, out_step}, 32'h1FFFF);
    send(8'd0, 8'd0);
    chk("wrap.0000", {15'd0, out_match, out_step}, 32'h10000);
    chk("wrap.err", 32'(err_count), 32'd0);
    chk("wrap.locked", 32'(locked), 32'd1);

    // Flywheel and unlock
    for (int s = 1; s <= 9; s++) send_step(16'(s));
    send(8'd0, 8'd0);
    chk("fly.bad_match", 32'(out_match), 32'd0);
    chk("fly.err1", 32'(err_count), 32'd1);
    send(8'd11, 8'd22);
    chk("fly.good_match", 32'(out_match), 32'd1);
    chk("fly.locked", 32'(locked), 32'd1);
    for (int i = 0; i < 3; i++) begin
      send(8'd0, 8'd0);
      chk($sformatf("unlock.err%0d", i), 32'(err_count), 32'(2 + i));
      chk($sformatf("unlock.locked%0d", i), 32'(locked), (i == 2) ? 32'd0 : 32'd1);
    end

    // Backpressure
    idle();
    out_ready = 1'b0;
    send_step(16'd100);
    in_valid = 1'b1; in_x = 8'd101; in_y = 8'd202;
    for (int i = 0; i < 5; i++) begin
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.hold", 32'(out_step), 32'd100);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp.next_step", 32'(out_step), 32'd101);
    chk("bp.next_match", 32'(out_match), 32'd1);
    idle();
    chk("bp.no_dup", 32'(out_valid), 32'd0);

    // Async reset mid-lock
    clear = 1'b1;
    send_step(16'd200);
    clear = 1'b0;
    for (int s = 201; s <= 203; s++) send_step(16'(s));
    chk("arst.locked_pre", 32'(locked), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst.out", {out_valid, out_match, locked, out_step}, 32'd0);
    chk("arst.err", 32'(err_count), 32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Clear with concurrent beat
    clear = 1'b1;
    send_step(16'd300);
    clear = 1'b0;
    for (int s = 301; s <= 303; s++) send_step(16'(s));
    send(8'd0, 8'd0);
    chk("clr.err_pre", 32'(err_count), 32'd1);
    clear = 1'b1;
    send_step(16'd500);
    clear = 1'b0;
    chk("clr.err", 32'(err_count), 32'd0);
    chk("clr.locked", 32'(locked), 32'd0);
    chk("clr.match", 32'(out_match), 32'd0);
    chk("clr.step", 32'(out_step), 32'd500);
    send_step(16'd501);
    send_step(16'd502);
    chk("relock.pre", 32'(locked), 32'd0);
    send_step(16'd503);
    chk("relock.locked", 32'(locked), 32'd1);
    chk("relock.match", 32'(out_match), 32'd1);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
